// File: rtl/pc_ras_unit.sv
// Program-counter unit with next-PC selection and a circular return-address stack.
// Calls push PC+1 and RET pops it. The PC and stack state hold whenever PC_EN is low.
module pc_ras_unit #(
   parameter int unsigned PC_W      = 16,
   parameter int unsigned JMP_W     = 11,
   parameter int unsigned RAS_DEPTH = 4,
   parameter int unsigned RESET_VEC = 0
) (
   input  logic                         CLK,
   input  logic                         CLR,
   input  logic                         PC_EN,
   input  logic                         PC_SE_flag,
   input  logic [PC_W-1:0]              SE_label,
   input  logic                         JMP_flag,
   input  logic [JMP_W-1:0]             jmp_label,
   input  logic                         JAL_flag,
   input  logic                         JAL_Rm_flag,
   input  logic [PC_W-1:0]              JAL_Rm,
   input  logic                         JR_flag,
   input  logic [PC_W-1:0]              JR_Rd,
   input  logic                         RET_flag,
   output logic [PC_W-1:0]              PC_o,
   output logic [PC_W-1:0]              link_o,
   output logic [$clog2(RAS_DEPTH):0]   ras_cnt_o,
   output logic                         ras_ovf_o,
   output logic                         ras_unf_o
);

   localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

   logic [PC_W-1:0]  pc_q, pc_n;
   logic [PC_W-1:0]  rel_target;
   logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
   logic [PTR_W-1:0] ptr_q, ptr_n;
   logic [CNT_W-1:0] cnt_q, cnt_n;
   logic             ovf_q, ovf_n, unf_q, unf_n;
   logic             push;

   assign link_o     = pc_q + PC_W'(1);
   assign rel_target = pc_q + SE_label;

   always_comb begin
      pc_n  = pc_q;
      ptr_n = ptr_q;
      cnt_n = cnt_q;
      ovf_n = ovf_q;
      unf_n = unf_q;
      push  = 1'b0;
      if (PC_EN) begin
         if (RET_flag) begin
            if (cnt_q != '0) begin
               pc_n  = ras_mem[ptr_q];
               ptr_n = ptr_q - PTR_W'(1);
               cnt_n = cnt_q - CNT_W'(1);
            end else begin
               pc_n  = link_o;
               unf_n = 1'b1;
            end
         end else if (JR_flag) begin
            pc_n = JR_Rd;
         end else if (JAL_Rm_flag) begin
            pc_n = JAL_Rm;
            push = 1'b1;
         end else if (JAL_flag) begin
            pc_n = rel_target;
            push = 1'b1;
         end else if (JMP_flag) begin
            pc_n = {pc_q[PC_W-1:JMP_W], jmp_label};
         end else if (PC_SE_flag) begin
            pc_n = rel_target;
         end else begin
            pc_n = link_o;
         end
      end
      // A push on a full stack overwrites the oldest entry; the count saturates.
      if (push) begin
         ptr_n = ptr_q + PTR_W'(1);
         if (cnt_q == CNT_FULL) ovf_n = 1'b1;
         else                   cnt_n = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         pc_q  <= PC_W'(RESET_VEC);
         ptr_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         pc_q  <= pc_n;
         ptr_q <= ptr_n;
         cnt_q <= cnt_n;
         ovf_q <= ovf_n;
         unf_q <= unf_n;
      end
   end

   always_ff @(posedge CLK) begin
      if (push) ras_mem[ptr_n] <= link_o;
   end

   assign PC_o      = pc_q;
   assign ras_cnt_o = cnt_q;
   assign ras_ovf_o = ovf_q;
   assign ras_unf_o = unf_q;

endmodule
